caliptra_axil_apb_bridge: RTL and testbench

//  AXI4-Lite slave to APB master bridge. Drives the Caliptra APB slave port (s_apb_*) of the

---
 rtl/caliptra_axil_apb_bridge.sv | 187 ++++++++++++++++++
 tb/tb_caliptra_axil_apb_bridge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/caliptra_axil_apb_bridge.sv
// AXI4-Lite slave to APB master bridge with round-robin read/write arbitration.
// One transaction in flight; APB PREADY timeout returns DECERR instead of stalling AXI.
module caliptra_axil_apb_bridge #(
  parameter int unsigned APB_ADDR_W = 40,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                    core_clk,
  input  logic                    S_AXI_ARESETN,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [31:0]             S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  input  logic [DATA_W-1:0]       S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]     S_AXI_WSTRB,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  output logic [1:0]              S_AXI_BRESP,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  input  logic [31:0]             S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [DATA_W-1:0]       S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [APB_ADDR_W-1:0]   m_apb_paddr,
  output logic [2:0]              m_apb_pprot,
  output logic [DATA_W-1:0]       m_apb_pwdata,
  output logic [DATA_W/8-1:0]     m_apb_pstrb,
  input  logic [DATA_W-1:0]       m_apb_prdata,
  input  logic                    m_apb_pready,
  input  logic                    m_apb_pslverr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                last_wr_q, last_wr_d;
  logic                wr_rdy_q, wr_rdy_d;
  logic                rd_rdy_q, rd_rdy_d;
  logic                dir_wr_q, dir_wr_d;
  logic [31:0]         addr_q, addr_d;
  logic [2:0]          prot_q, prot_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic [1:0]          resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic wr_elig, rd_elig, pick_wr, pick_rd, wr_hs, rd_hs, resp_hs;

  assign wr_elig = S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_elig = S_AXI_ARVALID;
  // On contention, serve the direction not served last.
  assign pick_wr = wr_elig & (~rd_elig | ~last_wr_q);
  assign pick_rd = rd_elig & ~pick_wr;
  assign wr_hs   = wr_rdy_q & wr_elig;
  assign rd_hs   = rd_rdy_q & rd_elig;
  assign resp_hs = (state_q == StResp) & (dir_wr_q ? S_AXI_BREADY : S_AXI_RREADY);

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    wr_rdy_d  = 1'b0;
    rd_rdy_d  = 1'b0;
    dir_wr_d  = dir_wr_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        if (wr_hs) begin
          dir_wr_d  = 1'b1;
          last_wr_d = 1'b1;
          addr_d    = S_AXI_AWADDR;
          prot_d    = S_AXI_AWPROT;
          wdata_d   = S_AXI_WDATA;
          strb_d    = S_AXI_WSTRB;
          cnt_d     = '0;
          state_d   = StSetup;
        end else if (rd_hs) begin
          dir_wr_d  = 1'b0;
          last_wr_d = 1'b0;
          addr_d    = S_AXI_ARADDR;
          prot_d    = S_AXI_ARPROT;
          wdata_d   = '0;
          strb_d    = '0;
          cnt_d     = '0;
          state_d   = StSetup;
        end else if (!wr_rdy_q && !rd_rdy_q) begin
          // READY is registered: raise it one cycle, the handshake lands on the next edge.
          wr_rdy_d = pick_wr;
          rd_rdy_d = pick_rd;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (m_apb_pready) begin
          resp_d  = m_apb_pslverr ? 2'b10 : 2'b00;
          rdata_d = dir_wr_q ? '0 : m_apb_prdata;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            resp_d  = 2'b11;
            rdata_d = '0;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (resp_hs) begin
          resp_d  = 2'b00;
          rdata_d = '0;
          state_d = StIdle;
          // Pre-arm READY so a waiting request is accepted the cycle after the handshake.
          wr_rdy_d = pick_wr;
          rd_rdy_d = pick_rd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge core_clk or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= StIdle;
      last_wr_q <= 1'b0;
      wr_rdy_q  <= 1'b0;
      rd_rdy_q  <= 1'b0;
      dir_wr_q  <= 1'b0;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      resp_q    <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      wr_rdy_q  <= wr_rdy_d;
      rd_rdy_q  <= rd_rdy_d;
      dir_wr_q  <= dir_wr_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign S_AXI_AWREADY = wr_rdy_q;
  assign S_AXI_WREADY  = wr_rdy_q;
  assign S_AXI_ARREADY = rd_rdy_q;
  assign S_AXI_BVALID  = (state_q == StResp) & dir_wr_q;
  assign S_AXI_RVALID  = (state_q == StResp) & ~dir_wr_q;
  assign S_AXI_BRESP   = resp_q;
  assign S_AXI_RRESP   = resp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign m_apb_psel    = (state_q == StSetup) | (state_q == StAccess);
  assign m_apb_penable = (state_q == StAccess);
  assign m_apb_pwrite  = dir_wr_q;
  assign m_apb_paddr   = {{(APB_ADDR_W - 32){1'b0}}, addr_q};
  assign m_apb_pprot   = prot_q;
  assign m_apb_pwdata  = wdata_q;
  assign m_apb_pstrb   = strb_q;

endmodule

// File: tb/tb_caliptra_axil_apb_bridge.sv
// Directed bench for caliptra_axil_apb_bridge: latency, arbitration, errors, timeout, reset.
module tb_caliptra_axil_apb_bridge;

  localparam int unsigned TO = 16;

  logic        core_clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata, prdata, pwdata;
  logic [2:0]  awprot, arprot, pprot;
  logic [3:0]  wstrb, pstrb;
  logic [1:0]  bresp, rresp;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [39:0] paddr;

  int total = 0;
  int bad   = 0;

  always #5 core_clk = ~core_clk;

  caliptra_axil_apb_bridge #(.APB_ADDR_W(40), .DATA_W(32), .TIMEOUT(TO)) dut (
    .core_clk(core_clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .m_apb_psel(psel), .m_apb_penable(penable), .m_apb_pwrite(pwrite), .m_apb_paddr(paddr),
    .m_apb_pprot(pprot), .m_apb_pwdata(pwdata), .m_apb_pstrb(pstrb),
    .m_apb_prdata(prdata), .m_apb_pready(pready), .m_apb_pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a write, wait for BVALID (bounded); lat counts cycles from the AW/W handshake.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    int n = 0;
    awaddr = a; awprot = 3'b000; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 50) begin @(negedge core_clk); n++; end
    @(negedge core_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    while (!bvalid && lat < 100) begin @(negedge core_clk); lat++; end
    resp = bresp;
    bready = 1'b1;
    @(negedge core_clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    int n = 0;
    araddr = a; arprot = 3'b000; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge core_clk); n++; end
    @(negedge core_clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 100) begin @(negedge core_clk); lat++; end
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    @(negedge core_clk);
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [2:0]  order;
    int          lat, n, n_psel, n_acc, k, both_hi;
    logic        ok;

    rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b1; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset state, with ARVALID held high to show READY stays low.
    repeat (3) @(negedge core_clk);
    check("rst_readys", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_apb_ctl", {psel, penable, pwrite}, 3'b000);
    check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    check("rst_paddr", paddr, 40'h0);
    arvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge core_clk);

    // 1: zero-wait write.
    awaddr = 32'h3000_0010; awprot = 3'b010; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; pready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge core_clk); n++; end
    check("t1_aw_w_ready", {awready, wready, arready}, 3'b110);
    @(negedge core_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("t1_setup_ctl", {psel, penable, pwrite, awready}, 4'b1010);
    check("t1_paddr", paddr, 40'h00_3000_0010);
    check("t1_pwdata", pwdata, 32'hDEAD_BEEF);
    check("t1_pstrb_pprot", {pstrb, pprot}, {4'hF, 3'b010});
    @(negedge core_clk);
    check("t1_access", {psel, penable, bvalid}, 3'b110);
    @(negedge core_clk);
    check("t1_bvalid_n3", {psel, penable, bvalid}, 3'b001);
    check("t1_bresp", bresp, 2'b00);
    bready = 1'b1;
    @(negedge core_clk);
    bready = 1'b0; pready = 1'b0;
    check("t1_bvalid_clr", bvalid, 1'b0);

    // 2: read with 5 wait states.
    araddr = 32'h3000_0000; arprot = 3'b001; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge core_clk); n++; end
    @(negedge core_clk);
    arvalid = 1'b0;
    check("t2_setup_rd", {psel, penable, pwrite, pstrb}, 7'b10_0_0000);
    check("t2_paddr", paddr, 40'h00_3000_0000);
    n_psel = 0; n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!psel && n_psel > 0) break;
      if (psel) n_psel++;
      if (penable) begin
        n_acc++;
        if (n_acc == 6) begin pready = 1'b1; prdata = 32'h1234_5678; end
      end
      @(negedge core_clk);
    end
    pready = 1'b0;
    check("t2_psel_cycles", n_psel, 7);
    check("t2_rvalid", {psel, rvalid, bvalid}, 3'b010);
    check("t2_rdata", rdata, 32'h1234_5678);
    check("t2_rresp", rresp, 2'b00);
    rready = 1'b1;
    @(negedge core_clk);
    rready = 1'b0;

    // 3: persistent contention after reset -> write, read, write.
    rst_n = 1'b0;
    @(negedge core_clk);
    rst_n = 1'b1;
    pready = 1'b1; bready = 1'b1; rready = 1'b1;
    awaddr = 32'h3000_0100; wdata = 32'h1111_2222; wstrb = 4'h3; araddr = 32'h3000_0200;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    order = 3'b000; k = 0; both_hi = 0;
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(negedge core_clk);
      if (awready && arready) both_hi++;
      if (awready) begin order[k] = 1'b1; k++; end
      else if (arready) begin order[k] = 1'b0; k++; end
    end
    @(negedge core_clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("t3_accept_count", k, 3);
    check("t3_order_w_r_w", order, 3'b101);
    check("t3_ready_exclusive", both_hi, 0);
    repeat (6) @(negedge core_clk);
    bready = 1'b0; rready = 1'b0;
    check("t3_drained", {psel, bvalid, rvalid}, 3'b000);

    // 4: slave error on write, then read timeout.
    pready = 1'b1; pslverr = 1'b1;
    axi_write(32'h3000_0020, 32'h5555_AAAA, 4'h1, resp, lat);
    check("t4_bresp_slverr", resp, 2'b10);
    check("t4_wr_latency", lat, 3);
    pready = 1'b0; pslverr = 1'b0; prdata = 32'hCAFE_F00D;
    axi_read(32'h3000_0024, d, resp, lat);
    check("t4_rresp_decerr", resp, 2'b11);
    check("t4_rdata_zero", d, 32'h0);
    check("t4_timeout_latency", lat, TO + 2);

    // 5: BREADY stalled while a read is waiting.
    pready = 1'b1; prdata = 32'h0BAD_F00D;
    awaddr = 32'h3000_0030; wdata = 32'h7777_8888; wstrb = 4'hC;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge core_clk); n++; end
    @(negedge core_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge core_clk); n++; end
    araddr = 32'h3000_0040; arvalid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!bvalid || bresp !== 2'b00 || arready || psel) ok = 1'b0;
      @(negedge core_clk);
    end
    check("t5_b_stable_ar_blocked", ok, 1'b1);
    bready = 1'b1;
    @(negedge core_clk);
    bready = 1'b0;
    check("t5_after_b_hs", {bvalid, arready}, 2'b01);
    @(negedge core_clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge core_clk); n++; end
    check("t5_rdata", {rvalid, rdata}, {1'b1, 32'h0BAD_F00D});
    rready = 1'b1;
    @(negedge core_clk);
    rready = 1'b0;

    // 6: reset during ACCESS.
    pready = 1'b0;
    awaddr = 32'h3000_0050; wdata = 32'h9999_0000; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge core_clk); n++; end
    @(negedge core_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge core_clk);
    check("t6_in_access", {psel, penable}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", {psel, penable, bvalid, rvalid}, 4'b0000);
    @(negedge core_clk);
    @(negedge core_clk);
    rst_n = 1'b1; pready = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      @(negedge core_clk);
      if (bvalid || rvalid || psel) ok = 1'b0;
    end
    check("t6_no_stale_resp", ok, 1'b1);
    axi_write(32'h3000_0060, 32'h0F0F_0F0F, 4'hF, resp, lat);
    check("t6_post_wr", {30'(lat), resp}, {30'd3, 2'b00});
    prdata = 32'hA5A5_5A5A;
    axi_read(32'h3000_0064, d, resp, lat);
    check("t6_post_rd", {d, resp}, {32'hA5A5_5A5A, 2'b00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
